// File: rtl/if_stage_pipelined_if.sv
// Fetch-stage bus: loader/hazard/branch controls in, IF/ID register and status out.
// IF_STEP_MODE_EN adds the single-step qualifier in_step.
interface if_stage_pipelined_if #(
  parameter int NB = 32
);
  logic          in_start;
  logic [NB-1:0] in_pc_jump_addr;
  logic [NB-1:0] in_pc_branch_addr;
  logic [NB-1:0] in_pc_jump_reg;
  logic          in_ctl_jump;
  logic          in_ctl_jump_reg;
  logic          in_ctl_branch;
  logic          in_stall;
  logic          in_flush;
  logic          in_imem_wr_en;
  logic [NB-1:0] in_imem_wr_addr;
  logic [NB-1:0] in_imem_wr_data;
`ifdef IF_STEP_MODE_EN
  logic          in_step;
`endif
  logic [NB-1:0] instruction_out;
  logic [NB-1:0] adder_out;
  logic [NB-1:0] out_pc;
  logic          out_valid;
  logic          out_halted;
  logic          out_misaligned;

  modport master (
    output in_start, in_pc_jump_addr, in_pc_branch_addr, in_pc_jump_reg,
    output in_ctl_jump, in_ctl_jump_reg, in_ctl_branch, in_stall, in_flush,
    output in_imem_wr_en, in_imem_wr_addr, in_imem_wr_data,
`ifdef IF_STEP_MODE_EN
    output in_step,
`endif
    input  instruction_out, adder_out, out_pc, out_valid, out_halted, out_misaligned
  );

  modport slave (
    input  in_start, in_pc_jump_addr, in_pc_branch_addr, in_pc_jump_reg,
    input  in_ctl_jump, in_ctl_jump_reg, in_ctl_branch, in_stall, in_flush,
    input  in_imem_wr_en, in_imem_wr_addr, in_imem_wr_data,
`ifdef IF_STEP_MODE_EN
    input  in_step,
`endif
    output instruction_out, adder_out, out_pc, out_valid, out_halted, out_misaligned
  );
endinterface

// File: rtl/if_stage_pipelined.sv
// MIPS instruction-fetch stage: PC, next-PC select, loadable word memory, IF/ID register,
// IDLE/RUN/HALTED control. Optional macro IF_STEP_MODE_EN gates RUN fetches with in_step.
module if_stage_pipelined #(
  parameter int            NB         = 32,
  parameter int            IMEM_DEPTH = 256,
  parameter logic [NB-1:0] PC_RESET   = '0,
  parameter logic [NB-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  if_stage_pipelined_if.slave  bus
);

  localparam int            AW     = $clog2(IMEM_DEPTH);
  localparam logic [NB-1:0] PC_INC = NB'(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [NB-1:0] r_mem [IMEM_DEPTH];
  logic [NB-1:0] r_pc;
  logic [NB-1:0] r_instr_p1;
  logic [NB-1:0] r_adder_p1;
  logic          r_vld_p1;
  logic          r_misaligned;

  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic [NB-1:0] w_instr;
  logic [NB-1:0] w_pc_plus4;
  logic [NB-1:0] w_target_raw;
  logic          w_redirect;
  logic [NB-1:0] w_next_pc;
  logic          w_target_mis;
  logic          w_is_halt;
  logic          w_go;
  logic          w_pc_we;
  logic          w_ifid_load;
  logic          w_ifid_clr;
  logic          w_mis_set;
  logic          w_unused;

  assign w_rd_idx   = r_pc[AW+1:2];
  assign w_wr_idx   = bus.in_imem_wr_addr[AW+1:2];
  assign w_instr    = r_mem[w_rd_idx];
  assign w_pc_plus4 = r_pc + PC_INC;
  assign w_is_halt  = (w_instr == HALT_WORD);
  assign w_unused   = ^{bus.in_imem_wr_addr[NB-1:AW+2], bus.in_imem_wr_addr[1:0]};

`ifdef IF_STEP_MODE_EN
  assign w_go = bus.in_step;
`else
  assign w_go = 1'b1;
`endif

  always_comb begin
    w_redirect   = 1'b1;
    w_target_raw = bus.in_pc_jump_reg;
    if (bus.in_ctl_jump_reg) begin
      w_target_raw = bus.in_pc_jump_reg;
    end else if (bus.in_ctl_jump) begin
      w_target_raw = bus.in_pc_jump_addr;
    end else if (bus.in_ctl_branch) begin
      w_target_raw = bus.in_pc_branch_addr;
    end else begin
      w_redirect   = 1'b0;
    end
  end

  // Redirect targets are forced onto a word boundary; the dropped bits raise the flag.
  assign w_next_pc    = w_redirect ? {w_target_raw[NB-1:2], 2'b00} : w_pc_plus4;
  assign w_target_mis = w_redirect & (|w_target_raw[1:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_ifid_load = 1'b0;
    w_ifid_clr  = 1'b0;
    w_mis_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ifid_clr = 1'b1;
        if (bus.in_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.in_flush) begin
          // Flush wins over stall and also cancels a HALT being fetched.
          w_pc_we    = 1'b1;
          w_ifid_clr = 1'b1;
          w_mis_set  = w_target_mis;
        end else if (!bus.in_stall && w_go) begin
          w_ifid_load = 1'b1;
          if (w_is_halt) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_pc_we   = 1'b1;
            w_mis_set = w_target_mis;
          end
        end
      end
      S_HALTED: begin
        w_ifid_clr = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ifid_clr  = 1'b1;
      end
    endcase
  end

  // Memory write port; a same-cycle read of the word sees the previous contents.
  always_ff @(posedge clk) begin
    if (reset && bus.in_imem_wr_en) begin
      r_mem[w_wr_idx] <= bus.in_imem_wr_data;
    end
  end

  // Stage boundary: PC -> IF/ID register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc         <= PC_RESET;
      r_instr_p1   <= '0;
      r_adder_p1   <= '0;
      r_vld_p1     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_pc_we) begin
        r_pc <= w_next_pc;
      end
      if (w_ifid_clr) begin
        r_instr_p1 <= '0;
        r_adder_p1 <= '0;
        r_vld_p1   <= 1'b0;
      end else if (w_ifid_load) begin
        r_instr_p1 <= w_instr;
        r_adder_p1 <= w_pc_plus4;
        r_vld_p1   <= 1'b1;
      end
      r_misaligned <= w_mis_set;
    end
  end

  assign bus.instruction_out = r_instr_p1;
  assign bus.adder_out       = r_adder_p1;
  assign bus.out_pc          = r_pc;
  assign bus.out_valid       = r_vld_p1;
  assign bus.out_halted      = (r_state == S_HALTED);
  assign bus.out_misaligned  = r_misaligned;

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Directed bench for if_stage_pipelined: the driver queues the expected post-edge view of
// every cycle, and an independent monitor pops and compares it just after each rising edge.
module tb_if_stage_pipelined;

  typedef struct {
    logic        en;
    logic [31:0] instr;
    logic [31:0] adder;
    logic        vld;
    logic [31:0] pc;
    logic        halted;
    logic        mis;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  logic drv_done;

  if_stage_pipelined_if #(.NB(32)) bus ();

  if_stage_pipelined #(
    .NB         (32),
    .IMEM_DEPTH (256),
    .PC_RESET   (32'h0),
    .HALT_WORD  (32'hFFFFFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.en) begin
          chk("instruction_out", bus.instruction_out, e.instr);
          chk("adder_out",       bus.adder_out,       e.adder);
          chk("out_valid",       32'(bus.out_valid),  32'(e.vld));
          chk("out_pc",          bus.out_pc,          e.pc);
          chk("out_halted",      32'(bus.out_halted), 32'(e.halted));
          chk("out_misaligned",  32'(bus.out_misaligned), 32'(e.mis));
        end
      end
    end
  end

  task automatic step(input logic en, input logic [31:0] ins, input logic [31:0] add,
                      input logic v, input logic [31:0] p, input logic h, input logic m);
    exp_t e;
    e.en = en; e.instr = ins; e.adder = add; e.vld = v; e.pc = p; e.halted = h; e.mis = m;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic ctl_off();
    bus.in_start        = 1'b0;
    bus.in_ctl_jump     = 1'b0;
    bus.in_ctl_jump_reg = 1'b0;
    bus.in_ctl_branch   = 1'b0;
    bus.in_stall        = 1'b0;
    bus.in_flush        = 1'b0;
    bus.in_imem_wr_en   = 1'b0;
  endtask

  // Reset cycle followed by the IDLE->RUN cycle
  task automatic restart();
    reset = 1'b0;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    bus.in_start = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_start = 1'b0;
  endtask

  initial begin
    drv_done = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    ctl_off();
    bus.in_pc_jump_addr   = '0;
    bus.in_pc_branch_addr = '0;
    bus.in_pc_jump_reg    = '0;
    bus.in_imem_wr_addr   = '0;
    bus.in_imem_wr_data   = '0;
`ifdef IF_STEP_MODE_EN
    bus.in_step = 1'b1;
`endif
    step(1, 0, 0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 0);

    // Load words 0..31 while IDLE: 0x11..0x44 then 0x100+i
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_imem_wr_en   = 1'b1;
      bus.in_imem_wr_addr = 32'(i * 4);
      bus.in_imem_wr_data = (i < 4) ? 32'(8'h11 * (i + 1)) : 32'(32'h100 + i);
      step(1, 0, 0, 0, 32'h0, 0, 0);
    end
    bus.in_imem_wr_en = 1'b0;

    restart();
    step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);

    // Stall with an ignored misaligned jump
    bus.in_stall = 1'b1;
    bus.in_ctl_jump = 1'b1;
    bus.in_pc_jump_addr = 32'h41;
    repeat (3) step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);
    bus.in_ctl_jump = 1'b0;
    bus.in_flush = 1'b1;
    bus.in_ctl_branch = 1'b1;
    bus.in_pc_branch_addr = 32'h10;
    step(1, 0, 0, 0, 32'h10, 0, 0);
    ctl_off();
    step(1, 32'h104, 32'h14, 1, 32'h14, 0, 0);

    // Redirect priority
    bus.in_ctl_jump_reg = 1'b1;
    bus.in_pc_jump_reg  = 32'h8;
    step(1, 32'h105, 32'h18, 1, 32'h8, 0, 0);
    bus.in_ctl_jump_reg = 1'b0;
    bus.in_ctl_jump = 1'b1;
    bus.in_ctl_branch = 1'b1;
    bus.in_pc_jump_addr = 32'h40;
    bus.in_pc_branch_addr = 32'h80;
    step(1, 32'h33, 32'hC, 1, 32'h40, 0, 0);
    bus.in_ctl_jump_reg = 1'b1;
    bus.in_pc_jump_reg  = 32'h20;
    step(1, 32'h110, 32'h44, 1, 32'h20, 0, 0);
    ctl_off();

    // Misaligned branch target
    bus.in_ctl_branch = 1'b1;
    bus.in_pc_branch_addr = 32'h13;
    step(1, 32'h108, 32'h24, 1, 32'h10, 0, 1);
    ctl_off();
    step(1, 32'h104, 32'h14, 1, 32'h14, 0, 0);
    step(1, 32'h105, 32'h18, 1, 32'h18, 0, 0);
    step(1, 32'h106, 32'h1C, 1, 32'h1C, 0, 0);

    // Reset mid-RUN overrides start; memory persists
    reset = 1'b0;
    bus.in_start = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_start = 1'b0;
    step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);
    step(1, 32'h22, 32'h8, 1, 32'h8, 0, 0);
    step(1, 32'h33, 32'hC, 1, 32'hC, 0, 0);

    // HALT at word 2
    reset = 1'b0;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    bus.in_imem_wr_en = 1'b1;
    bus.in_imem_wr_addr = 32'h8;
    bus.in_imem_wr_data = 32'hFFFFFFFF;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_imem_wr_en = 1'b0;
    bus.in_start = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_start = 1'b0;
    step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);
    step(1, 32'h22, 32'h8, 1, 32'h8, 0, 0);
    step(1, 32'hFFFFFFFF, 32'hC, 1, 32'h8, 1, 0);
    step(1, 0, 0, 0, 32'h8, 1, 0);
    bus.in_start = 1'b1;
    step(1, 0, 0, 0, 32'h8, 1, 0);
    bus.in_start = 1'b0;
    bus.in_ctl_jump = 1'b1;
    bus.in_pc_jump_addr = 32'h40;
    step(1, 0, 0, 0, 32'h8, 1, 0);
    ctl_off();

    // Flush cancels the HALT fetch; stall defers it
    restart();
    step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);
    step(1, 32'h22, 32'h8, 1, 32'h8, 0, 0);
    bus.in_flush = 1'b1;
    step(1, 0, 0, 0, 32'hC, 0, 0);
    bus.in_flush = 1'b0;
    step(1, 32'h44, 32'h10, 1, 32'h10, 0, 0);
    bus.in_ctl_jump_reg = 1'b1;
    bus.in_pc_jump_reg = 32'h8;
    step(1, 32'h104, 32'h14, 1, 32'h8, 0, 0);
    bus.in_ctl_jump_reg = 1'b0;
    bus.in_stall = 1'b1;
    step(1, 32'h104, 32'h14, 1, 32'h8, 0, 0);
    bus.in_stall = 1'b0;
    step(1, 32'hFFFFFFFF, 32'hC, 1, 32'h8, 1, 0);
    step(1, 0, 0, 0, 32'h8, 1, 0);

    // Aliased write to word 255 and PC+4 wrap-around
    reset = 1'b0;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    bus.in_imem_wr_en = 1'b1;
    bus.in_imem_wr_addr = 32'h7FC;
    bus.in_imem_wr_data = 32'hABCD;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_imem_wr_en = 1'b0;
    bus.in_start = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0, 0);
    bus.in_start = 1'b0;
    bus.in_ctl_jump_reg = 1'b1;
    bus.in_pc_jump_reg = 32'hFFFFFFFC;
    step(1, 32'h11, 32'h4, 1, 32'hFFFFFFFC, 0, 0);
    ctl_off();
    step(1, 32'hABCD, 32'h0, 1, 32'h0, 0, 0);
    step(1, 32'h11, 32'h4, 1, 32'h4, 0, 0);

    drv_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!drv_done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (!drv_done || q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: done=%0d pending=%0d, expected done=1 pending=0", drv_done, q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
